// File: rtl/i2c_phase_timer_if.sv
// Control/status bundle between the I2C master FSM and the multi-phase bit timer.
// The master modport drives control and observes timing pulses; the slave modport is the timer.
interface i2c_phase_timer_if #(
   parameter int unsigned SIZE    = 16,
   parameter int unsigned PHASES  = 4,
   parameter int unsigned TO_SIZE = 20
);
   localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;

   logic               start;
   logic               stop;
   logic               mode;
   logic               hold;
   logic [SIZE-1:0]    ticks;
   logic [TO_SIZE-1:0] timeout_ticks;
   logic [PHASES-1:0]  phase;
   logic [IDX_W-1:0]   phase_idx;
   logic               bit_done;
   logic               busy;
   logic               timeout;

   modport master (
      output start, stop, mode, hold, ticks, timeout_ticks,
      input  phase, phase_idx, bit_done, busy, timeout
   );

   modport slave (
      input  start, stop, mode, hold, ticks, timeout_ticks,
      output phase, phase_idx, bit_done, busy, timeout
   );
endinterface

// File: rtl/i2c_phase_timer.sv
// Multi-phase I2C bit timer: splits each bit into PHASES equal phases, with SCL
// stretch support on entry to HOLD_PHASE (assumed 1..PHASES-1) and a stretch timeout.
module i2c_phase_timer #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned PHASES     = 4,
   parameter int unsigned HOLD_PHASE = 2,
   parameter int unsigned TO_SIZE    = 20
) (
   input logic               clk_i,
   input logic               rst_ni,
   i2c_phase_timer_if.slave  ctrl_io
);
   localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STRETCH = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SIZE-1:0]    ticks_q, ticks_d;
   logic               mode_q, mode_d;
   logic [SIZE-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TO_SIZE-1:0] s_q, s_d;
   logic [PHASES-1:0]  phase_q, phase_d;
   logic               bit_done_q, bit_done_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;
   logic [SIZE-1:0]    ticks_eff_c;

   assign ticks_eff_c = (ctrl_io.ticks == '0) ? SIZE'(1) : ctrl_io.ticks;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ticks_q    <= '0;
         mode_q     <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         s_q        <= '0;
         phase_q    <= '0;
         bit_done_q <= 1'b0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ticks_q    <= ticks_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         s_q        <= s_d;
         phase_q    <= phase_d;
         bit_done_q <= bit_done_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next state and registered outputs; pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      ticks_d    = ticks_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      s_d        = s_q;
      phase_d    = '0;
      bit_done_d = 1'b0;
      busy_d     = busy_q;
      timeout_d  = 1'b0;

      if (ctrl_io.stop) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         s_d     = '0;
         busy_d  = 1'b0;
      end else if (ctrl_io.start) begin
         state_d = RUN;
         ticks_d = ticks_eff_c;
         mode_d  = ctrl_io.mode;
         cnt_d   = ticks_eff_c - SIZE'(1);
         idx_d   = '0;
         s_d     = '0;
         phase_d = PHASES'(1);
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               busy_d = 1'b0;
            end
            RUN: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - SIZE'(1);
               end else if (idx_q == IDX_W'(PHASES - 1)) begin
                  bit_done_d = 1'b1;
                  idx_d      = '0;
                  if (mode_q) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     cnt_d   = ticks_q - SIZE'(1);
                     phase_d = PHASES'(1);
                  end
               end else if ((idx_q == IDX_W'(HOLD_PHASE - 1)) && ctrl_io.hold) begin
                  // Slave holds SCL low: freeze the phase counter until released.
                  state_d = STRETCH;
                  s_d     = TO_SIZE'(1);
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  cnt_d   = ticks_q - SIZE'(1);
                  phase_d = PHASES'(1) << (idx_q + IDX_W'(1));
               end
            end
            STRETCH: begin
               if (!ctrl_io.hold) begin
                  state_d = RUN;
                  idx_d   = IDX_W'(HOLD_PHASE);
                  cnt_d   = ticks_q - SIZE'(1);
                  phase_d = PHASES'(1) << HOLD_PHASE;
                  s_d     = '0;
               end else if ((ctrl_io.timeout_ticks != '0) && (s_q >= ctrl_io.timeout_ticks)) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  idx_d     = '0;
                  s_d       = '0;
                  busy_d    = 1'b0;
               end else if (s_q != '1) begin
                  s_d = s_q + TO_SIZE'(1);
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               s_d     = '0;
            end
         endcase
      end
   end

   assign ctrl_io.phase     = phase_q;
   assign ctrl_io.phase_idx = idx_q;
   assign ctrl_io.bit_done  = bit_done_q;
   assign ctrl_io.busy      = busy_q;
   assign ctrl_io.timeout   = timeout_q;

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Bench for i2c_phase_timer: directed stimulus queues cycle-stamped expected outputs,
// a negedge monitor compares them and flags any pulse nobody asked for.
module tb_i2c_phase_timer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int         c;
      int         tid;
      logic [3:0] ph;
      logic [1:0] ix;
      logic       bd;
      logic       bz;
      logic       to;
   } exp_t;

   exp_t exp_q[$];

   i2c_phase_timer_if #(.SIZE(16), .PHASES(4), .TO_SIZE(20)) bus ();

   i2c_phase_timer #(.SIZE(16), .PHASES(4), .HOLD_PHASE(2), .TO_SIZE(20)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .ctrl_io (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expect_at(int c, int tid, logic [3:0] ph, logic [1:0] ix,
                                     logic bd, logic bz, logic to);
      exp_t e;
      e.c = c; e.tid = tid; e.ph = ph; e.ix = ix; e.bd = bd; e.bz = bz; e.to = to;
      exp_q.push_back(e);
   endfunction

   function automatic void expect_idle(int c, int tid);
      expect_at(c, tid, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   // Monitor: compare the expectation due this cycle, otherwise any pulse is unexpected.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL test%0d missed expectation for cycle %0d (now %0d)", exp_q[0].tid, exp_q[0].c, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.phase !== e.ph || bus.phase_idx !== e.ix || bus.bit_done !== e.bd ||
                bus.busy !== e.bz || bus.timeout !== e.to) begin
               errors++;
               $display("FAIL test%0d cyc=%0d got phase=%b idx=%0d bd=%b busy=%b to=%b, want phase=%b idx=%0d bd=%b busy=%b to=%b",
                        e.tid, cyc, bus.phase, bus.phase_idx, bus.bit_done, bus.busy, bus.timeout,
                        e.ph, e.ix, e.bd, e.bz, e.to);
            end
         end else if ((|bus.phase) || bus.bit_done || bus.timeout) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got phase=%b bd=%b to=%b, want no pulse",
                     cyc, bus.phase, bus.bit_done, bus.timeout);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(int c);
      while (cyc < c) step();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.mode = 1'b0;
      bus.hold = 1'b0;
      bus.ticks = 16'd0;
      bus.timeout_ticks = 20'd0;
      step(); step(); step();
      expect_idle(cyc, 0);
      mon_en = 1'b1;
      step();
      rst_n = 1'b1;
      step(); step();

      // 1: reset mid-run, with Start held during reset
      bus.ticks = 16'd5; bus.mode = 1'b0;
      t = cyc;
      expect_at(t + 1, 1, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_idle(t + 4, 1);
      expect_idle(t + 5, 1);
      expect_idle(t + 6, 1);
      pulse_start();
      wait_until(t + 3);
      rst_n = 1'b0; bus.start = 1'b1;
      step(); step();
      rst_n = 1'b1; bus.start = 1'b0;
      wait_until(t + 10);

      // 2: one-shot, T=5
      bus.ticks = 16'd5; bus.mode = 1'b1;
      t = cyc;
      expect_at(t + 1,  2, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 6,  2, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 11, 2, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
      expect_at(t + 16, 2, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at(t + 21, 2, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      expect_idle(t + 22, 2);
      pulse_start();
      wait_until(t + 25);

      // 3: cyclic, T=3, three bits, Ticks/Mode changed mid-run, then Stop
      bus.ticks = 16'd3; bus.mode = 1'b0;
      t = cyc;
      for (int k = 0; k <= 12; k++)
         expect_at(t + 1 + 3 * k, 3, 4'(1 << (k % 4)), 2'(k % 4),
                   ((k % 4) == 0) && (k > 0), 1'b1, 1'b0);
      expect_at(t + 38, 3, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_idle(t + 39, 3);
      expect_idle(t + 40, 3);
      pulse_start();
      bus.ticks = 16'd7; bus.mode = 1'b1;
      wait_until(t + 38);
      pulse_stop();
      wait_until(t + 44);

      // 4: stretch of 10 cycles at the phase 1 -> 2 boundary, T=4, one-shot
      bus.ticks = 16'd4; bus.mode = 1'b1; bus.timeout_ticks = 20'd0;
      t = cyc;
      expect_at(t + 1,  4, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 5,  4, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 12, 4, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 19, 4, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
      expect_at(t + 23, 4, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at(t + 27, 4, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      pulse_start();
      wait_until(t + 8);
      bus.hold = 1'b1;
      wait_until(t + 18);
      bus.hold = 1'b0;
      wait_until(t + 31);

      // 5: Hold stuck, timeout after 8 stretch cycles; Hold ignored at phase 0 -> 1
      bus.ticks = 16'd2; bus.mode = 1'b0; bus.timeout_ticks = 20'd8; bus.hold = 1'b1;
      t = cyc;
      expect_at(t + 1,  5, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 3,  5, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 8,  5, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 12, 5, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 13, 5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
      expect_idle(t + 14, 5);
      pulse_start();
      wait_until(t + 15);
      bus.hold = 1'b0;
      wait_until(t + 18);

      // 6: Stop during stretch gives no Timeout
      bus.hold = 1'b1;
      t = cyc;
      expect_at(t + 1, 6, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 3, 6, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_idle(t + 9, 6);
      expect_idle(t + 13, 6);
      pulse_start();
      wait_until(t + 8);
      pulse_stop();
      wait_until(t + 15);
      bus.hold = 1'b0;
      bus.timeout_ticks = 20'd0;
      wait_until(t + 17);

      // 7: Ticks=0 with Start+Stop (Stop wins), then Start alone at T=1
      bus.ticks = 16'd0; bus.mode = 1'b0;
      t = cyc;
      expect_idle(t + 1, 7);
      for (int k = 0; k <= 8; k++)
         expect_at(t + 3 + k, 7, 4'(1 << (k % 4)), 2'(k % 4),
                   ((k % 4) == 0) && (k > 0), 1'b1, 1'b0);
      expect_idle(t + 12, 7);
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      bus.start = 1'b0; bus.stop = 1'b0;
      wait_until(t + 2);
      pulse_start();
      wait_until(t + 11);
      pulse_stop();
      wait_until(t + 15);

      // 8: Start while busy restarts at phase 0 with no Bit_done for the aborted bit
      bus.ticks = 16'd3; bus.mode = 1'b1;
      t = cyc;
      expect_at(t + 1,  8, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 4,  8, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 6,  8, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
      expect_at(t + 9,  8, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      expect_at(t + 12, 8, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
      expect_at(t + 15, 8, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0);
      expect_at(t + 18, 8, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
      expect_idle(t + 19, 8);
      pulse_start();
      wait_until(t + 5);
      pulse_start();
      wait_until(t + 24);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expectations, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
